inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue_pkg.sv | 27 ++
 rtl/inst_fetch_queue_if.sv | 61 ++++++
 rtl/ifq_storage_2w2r.sv | 33 +++
 rtl/inst_fetch_queue.sv | 114 +++++++++++
 tb/tb_inst_fetch_queue.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared processor constants and types.
// Queue, ROB and reservation-station sizing live side by side here.
package inst_fetch_queue_pkg;

  localparam int ROB_DEPTH      = 16;
  localparam int RS_ARITH_DEPTH = 4;

  localparam int INSTR_W     = 32;
  localparam int PC_W        = 10;

  localparam int IFQ_DEPTH   = 8;
  localparam int IFQ_PTR_W   = $clog2(IFQ_DEPTH);
  localparam int IFQ_CNT_W   = IFQ_PTR_W + 1;
  localparam int IFQ_ENTRY_W = INSTR_W + PC_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } ifq_entry_t;

  function automatic logic [PC_W-1:0] pc_next(
    input logic [PC_W-1:0] pc
  );
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side and dispatch-side bundle of the instruction queue.
// master drives fetch and stall/flush, slave is the queue.
interface inst_fetch_queue_if
  import inst_fetch_queue_pkg::*;
#(
  parameter int CNT_W = IFQ_CNT_W
) ();

  logic               flush;
  logic               fetch_valid;
  logic [INSTR_W-1:0] fetch_instr1;
  logic [INSTR_W-1:0] fetch_instr2;
  logic [PC_W-1:0]    fetch_pc;
  logic               fetch_ready;
  logic               disp_stall;
  logic               disp_valid1;
  logic               disp_valid2;
  logic [INSTR_W-1:0] disp_instr1;
  logic [INSTR_W-1:0] disp_instr2;
  logic [PC_W-1:0]    disp_pc1;
  logic [PC_W-1:0]    disp_pc2;
  logic [CNT_W-1:0]   count;
  logic               overflow_err;

  modport master (
    output flush,
    output fetch_valid,
    output fetch_instr1,
    output fetch_instr2,
    output fetch_pc,
    output disp_stall,
    input  fetch_ready,
    input  disp_valid1,
    input  disp_valid2,
    input  disp_instr1,
    input  disp_instr2,
    input  disp_pc1,
    input  disp_pc2,
    input  count,
    input  overflow_err
  );

  modport slave (
    input  flush,
    input  fetch_valid,
    input  fetch_instr1,
    input  fetch_instr2,
    input  fetch_pc,
    input  disp_stall,
    output fetch_ready,
    output disp_valid1,
    output disp_valid2,
    output disp_instr1,
    output disp_instr2,
    output disp_pc1,
    output disp_pc2,
    output count,
    output overflow_err
  );

endinterface

// File: rtl/ifq_storage_2w2r.sv
// Entry array for the fetch queue: two writes, two async reads.
// Contents are never reset; validity is tracked by the owner.
module ifq_storage_2w2r
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [AW-1:0] waddr0,
  input  ifq_entry_t    wdata0,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  ifq_entry_t    wdata1,
  input  logic [AW-1:0] raddr0,
  output ifq_entry_t    rdata0,
  input  logic [AW-1:0] raddr1,
  output ifq_entry_t    rdata1
);

  ifq_entry_t mem [DEPTH];

  // Write both halves of a fetched pair in the same cycle.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_fetch_queue.sv
// Two-wide instruction queue between fetch and dispatch.
// Show-ahead head pair, pair push, 0/1/2 pop per cycle.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_queue_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  logic          ready;
  logic          push;
  logic          drop;
  logic [1:0]    pop_n;
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;

  ifq_entry_t    wr0;
  ifq_entry_t    wr1;
  ifq_entry_t    rd0;
  ifq_entry_t    rd1;

  assign ready   = count_q <= CW'(DEPTH - 2);
  assign push    = bus.fetch_valid & ready & ~bus.flush;
  assign drop    = bus.fetch_valid & ~ready & ~bus.flush;
  assign head_p1 = head_q + PW'(1);
  assign tail_p1 = tail_q + PW'(1);

  assign wr0.instr = bus.fetch_instr1;
  assign wr0.pc    = bus.fetch_pc;
  assign wr1.instr = bus.fetch_instr2;
  assign wr1.pc    = pc_next(bus.fetch_pc);

  ifq_storage_2w2r #(
    .DEPTH (DEPTH)
  ) u_store (
    .clk    (clk),
    .we0    (push),
    .waddr0 (tail_q),
    .wdata0 (wr0),
    .we1    (push),
    .waddr1 (tail_p1),
    .wdata1 (wr1),
    .raddr0 (head_q),
    .rdata0 (rd0),
    .raddr1 (head_p1),
    .rdata1 (rd1)
  );

  // Dispatch takes up to two entries unless stalled.
  always_comb begin
    pop_n = 2'd0;
    if (!bus.disp_stall) begin
      if (count_q >= CW'(2)) pop_n = 2'd2;
      else                   pop_n = count_q[1:0];
    end
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(2);
      head_q  <= head_q + PW'(pop_n);
      count_q <= count_q
               + (push ? CW'(2) : CW'(0))
               - CW'(pop_n);
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Zero the dispatch slots that do not hold a live entry.
  always_comb begin
    bus.disp_valid1 = 1'b0;
    bus.disp_instr1 = '0;
    bus.disp_pc1    = '0;
    bus.disp_valid2 = 1'b0;
    bus.disp_instr2 = '0;
    bus.disp_pc2    = '0;
    if (count_q != '0) begin
      bus.disp_valid1 = 1'b1;
      bus.disp_instr1 = rd0.instr;
      bus.disp_pc1    = rd0.pc;
    end
    if (count_q >= CW'(2)) begin
      bus.disp_valid2 = 1'b1;
      bus.disp_instr2 = rd1.instr;
      bus.disp_pc2    = rd1.pc;
    end
  end

  assign bus.fetch_ready  = ready;
  assign bus.count        = count_q;
  assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: queue model, per-cycle compare,
// directed scenarios with literal expectations, random traffic.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int DEPTH = IFQ_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inst_fetch_queue_if ifc ();

  inst_fetch_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  pc;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf;

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, got, exp, $time);
    end
  endtask

  // Reference queue: flush clears, pops come off the front,
  // a pair is appended when at least two slots were free.
  always @(posedge clk or negedge rst) begin : model
    int          sz;
    int          np;
    logic [9:0]  p2;
    if (!rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (ifc.flush) begin
      mq.delete();
    end else begin
      sz = mq.size();
      np = ifc.disp_stall ? 0 : (sz < 2 ? sz : 2);
      repeat (np) void'(mq.pop_front());
      if (ifc.fetch_valid) begin
        if (DEPTH - sz >= 2) begin
          p2 = ifc.fetch_pc + 10'd1;
          mq.push_back('{ifc.fetch_instr1, ifc.fetch_pc});
          mq.push_back('{ifc.fetch_instr2, p2});
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    int sz;
    if (chk_en && rst) begin
      sz = mq.size();
      chk("count", 32'(ifc.count), 32'(sz));
      chk("fetch_ready", 32'(ifc.fetch_ready),
          32'((DEPTH - sz) >= 2));
      chk("overflow_err", 32'(ifc.overflow_err), 32'(m_ovf));
      chk("disp_valid1", 32'(ifc.disp_valid1), 32'(sz >= 1));
      chk("disp_valid2", 32'(ifc.disp_valid2), 32'(sz >= 2));
      if (sz >= 1) begin
        chk("disp_instr1", ifc.disp_instr1, mq[0].instr);
        chk("disp_pc1", 32'(ifc.disp_pc1), 32'(mq[0].pc));
      end else begin
        chk("disp_instr1", ifc.disp_instr1, 32'd0);
        chk("disp_pc1", 32'(ifc.disp_pc1), 32'd0);
      end
      if (sz >= 2) begin
        chk("disp_instr2", ifc.disp_instr2, mq[1].instr);
        chk("disp_pc2", 32'(ifc.disp_pc2), 32'(mq[1].pc));
      end else begin
        chk("disp_instr2", ifc.disp_instr2, 32'd0);
        chk("disp_pc2", 32'(ifc.disp_pc2), 32'd0);
      end
    end
  end

  task automatic drive(bit fv, logic [31:0] i1, logic [31:0] i2,
                       logic [9:0] pc, bit st, bit fl);
    @(negedge clk);
    ifc.fetch_valid  = fv;
    ifc.fetch_instr1 = i1;
    ifc.fetch_instr2 = i2;
    ifc.fetch_pc     = pc;
    ifc.disp_stall   = st;
    ifc.flush        = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.fetch_valid = 1'b0;
    ifc.disp_stall  = 1'b1;
    ifc.flush       = 1'b0;
  endtask

  initial begin
    ifc.fetch_valid  = 1'b0;
    ifc.fetch_instr1 = '0;
    ifc.fetch_instr2 = '0;
    ifc.fetch_pc     = '0;
    ifc.disp_stall   = 1'b0;
    ifc.flush        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(ifc.count), 32'd0);
    chk("rst_ready", 32'(ifc.fetch_ready), 32'd1);
    chk("rst_valid1", 32'(ifc.disp_valid1), 32'd0);
    chk("rst_pc1", 32'(ifc.disp_pc1), 32'd0);
    chk("rst_ovf", 32'(ifc.overflow_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // Reset then push: visible next cycle.
    drive(1, 32'h20010005, 32'h20020007, 10'd0, 0, 0);
    chk("s1_valid1", 32'(ifc.disp_valid1), 32'd1);
    chk("s1_valid2", 32'(ifc.disp_valid2), 32'd1);
    chk("s1_instr1", ifc.disp_instr1, 32'h20010005);
    chk("s1_instr2", ifc.disp_instr2, 32'h20020007);
    chk("s1_pc1", 32'(ifc.disp_pc1), 32'd0);
    chk("s1_pc2", 32'(ifc.disp_pc2), 32'd1);
    chk("s1_count", 32'(ifc.count), 32'd2);

    // Fill under stall, then one dropped pair.
    drive(0, 0, 0, 0, 1, 1);
    chk("flush_count", 32'(ifc.count), 32'd0);
    for (int k = 0; k < 4; k++)
      drive(1, 32'h100 + k, 32'h200 + k, 10'(10 * k), 1, 0);
    chk("fill_count", 32'(ifc.count), 32'd8);
    chk("fill_ready", 32'(ifc.fetch_ready), 32'd0);
    chk("fill_ovf", 32'(ifc.overflow_err), 32'd0);
    drive(1, 32'hdead, 32'hbeef, 10'd77, 1, 0);
    chk("ovf_set", 32'(ifc.overflow_err), 32'd1);
    chk("ovf_count", 32'(ifc.count), 32'd8);
    chk("ovf_pc1", 32'(ifc.disp_pc1), 32'd0);

    // Drain: pops of two until empty.
    drive(0, 0, 0, 0, 1, 1);
    chk("flush_keeps_ovf", 32'(ifc.overflow_err), 32'd1);
    drive(1, 32'h11, 32'h12, 10'd40, 1, 0);
    drive(1, 32'h13, 32'h14, 10'd50, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("drain_count2", 32'(ifc.count), 32'd2);
    chk("drain_pc1", 32'(ifc.disp_pc1), 32'd50);
    drive(0, 0, 0, 0, 0, 0);
    chk("drain_count0", 32'(ifc.count), 32'd0);
    chk("drain_valid1", 32'(ifc.disp_valid1), 32'd0);

    // Simultaneous push and pop across the pointer wrap.
    drive(0, 0, 0, 0, 1, 1);
    drive(1, 32'ha0, 32'ha1, 10'd100, 1, 0);
    drive(1, 32'hb0, 32'hb1, 10'd200, 1, 0);
    drive(1, 32'hc0, 32'hc1, 10'd300, 1, 0);
    drive(1, 32'hd0, 32'hd1, 10'd400, 0, 0);
    chk("pp_count", 32'(ifc.count), 32'd6);
    chk("pp_pc1", 32'(ifc.disp_pc1), 32'd200);
    chk("pp_instr2", ifc.disp_instr2, 32'hb1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("pp_wrap_pc1", 32'(ifc.disp_pc1), 32'd400);
    chk("pp_wrap_instr2", ifc.disp_instr2, 32'hd1);

    // Flush beats a concurrent push and pop.
    drive(1, 32'he0, 32'he1, 10'd500, 1, 0);
    drive(1, 32'hf0, 32'hf1, 10'd600, 0, 1);
    chk("fl_count", 32'(ifc.count), 32'd0);
    chk("fl_valid1", 32'(ifc.disp_valid1), 32'd0);
    chk("fl_ovf", 32'(ifc.overflow_err), 32'd1);

    // PC wraps modulo 1024 for the second slot.
    drive(1, 32'h1234, 32'h5678, 10'd1023, 1, 0);
    chk("pcw_pc1", 32'(ifc.disp_pc1), 32'd1023);
    chk("pcw_pc2", 32'(ifc.disp_pc2), 32'd0);

    // Reset mid-operation, then a push on the empty queue.
    drive(1, 32'h9, 32'ha, 10'd8, 1, 0);
    @(negedge clk);
    idle();
    #2 rst = 1'b0;
    #1;
    chk("mrst_count", 32'(ifc.count), 32'd0);
    chk("mrst_ovf", 32'(ifc.overflow_err), 32'd0);
    chk("mrst_ready", 32'(ifc.fetch_ready), 32'd1);
    chk("mrst_valid1", 32'(ifc.disp_valid1), 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    drive(1, 32'h77, 32'h78, 10'd7, 0, 0);
    chk("prst_count", 32'(ifc.count), 32'd2);
    chk("prst_pc1", 32'(ifc.disp_pc1), 32'd7);
    chk("prst_instr2", ifc.disp_instr2, 32'h78);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ifc.fetch_valid  = ($urandom_range(99) < 65);
      ifc.fetch_instr1 = $urandom;
      ifc.fetch_instr2 = $urandom;
      ifc.fetch_pc     = 10'($urandom);
      ifc.disp_stall   = ($urandom_range(99) < 50);
      ifc.flush        = ($urandom_range(99) < 3);
      if ($urandom_range(499) == 0) begin
        #2 rst = 1'b0;
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
